neuron_mac_seq: RTL and testbench
=================================

// Module: neuron_mac_seq
// PURPOSE
//  Parametrised sequential weighted-sum neuron: C = B + sum(X[i] ? W[i] : 0) over N_IN binary pixels.
//  Processes LANES pixels per cycle under a valid/ready handshake; result is held until consumed.
//  Sits between the pixel-window source and the classifier stage, and replaces fixed 9-input combinational mean/weight units.
// PARAMETERS
//  N_IN   9   number of binary pixel inputs per frame (>=1)
//  W      20  signed width of weights, bias and output
//  LANES  1   pixels accumulated per cycle (1..N_IN; N_IN need not be a multiple)
// PORTS
//  clk        in   1        single clock, rising edge
//  rst_n      in   1        reset, synchronous, active-low
//  in_valid   in   1        frame request valid
//  in_ready   out  1        block can accept a frame
//  in_x       in   N_IN     pixel bits, bit i = X_i; captured on accept
//  in_w       in   N_IN*W   packed signed weights, W[i] = in_w[i*W +: W]; must be held stable while busy=1
//  in_b       in   W        signed bias; captured on accept
//  out_valid  out  1        result valid
//  out_ready  in   1        downstream accepts result
//  out_c      out  W        signed result
//  out_sat    out  1        result was clipped (only meaningful with NEURON_SAT_EN)
//  busy       out  1        FSM not IDLE
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): state=IDLE; out_valid=0, out_c=0, out_sat=0, busy=0, acc=0, idx=0; in_ready=1 next cycle.
//  - Reset mid-ACCUM/DONE aborts the frame; partial sum is discarded; no out_valid pulse.
//  - BEATS = ceil(N_IN/LANES); ACC_W = W + $clog2(N_IN+1); all terms sign-extended to ACC_W.
//  - IDLE: in_ready=1. On in_valid: latch in_x, acc<=sext(in_b), idx<=0 -> ACCUM.
//  - ACCUM: in_ready=0. Each cycle acc += W[j] for j in idx..idx+LANES-1 where j<N_IN and X[j]=1;
//    indices >= N_IN contribute 0. idx += LANES. On the last beat, register the final value into out_c/out_sat -> DONE.
//  - DONE: out_valid=1; out_c/out_sat stable while out_ready=0. in_ready = out_ready.
//    out_ready=1 and in_valid=0: -> IDLE, out_valid=0 next cycle.
//    out_ready=1 and in_valid=1: result pops and new frame is captured in the same edge -> ACCUM (no bubble).
//  - Latency: out_valid rises BEATS cycles after the accepting edge (N_IN=9,LANES=1: 9; LANES=3: 3).
//  - Throughput: one frame per BEATS+1 cycles under ideal back-to-back handshakes.
//  - in_valid while in_ready=0 is ignored (frame held upstream); in_x/in_b are sampled only on accept.
// CONFIGURATION
//  NEURON_SAT_EN defined: final acc clamped to [-2^(W-1), 2^(W-1)-1]; out_sat=1 iff clamped.
//  NEURON_SAT_EN undefined: out_c = acc[W-1:0] (two's-complement wrap); out_sat tied 0.
// STRUCTURE
//  neuron_pkg: state enum typedef (IDLE, ACCUM, DONE); function acc_w(n_in,w); function beats(n_in,lanes).
//  Sub-module neuron_sat: ACC_W->W saturate/wrap narrowing with sat flag; holds the NEURON_SAT_EN ifdef.
//  Top: FSM, idx counter, LANES-wide masked adder tree, output registers.
// TESTING (N_IN=9, W=20, LANES=1 unless noted)
//  1 in_x=9'h1FF, W[i]=i+1, B=10, out_ready=1 -> out_valid 9 cycles after accept, out_c=55, out_sat=0.
//  2 in_x=0, any W, B=-5 -> out_c=-5 (20'hFFFFB); in_x=9'b000010001, W[i]=-100, B=0 -> out_c=-200.
//  3 in_x=9'h1FF, all W=20'h7FFFF, B=0 -> NEURON_SAT_EN: out_c=20'h7FFFF, out_sat=1; without: out_c=20'h7FFF7, out_sat=0.
//  4 Backpressure: out_ready=0 for 5 cycles in DONE -> out_c stable, in_ready=0; then out_ready=1 with in_valid=1
//    -> second frame accepted on the same edge, its result arrives 9 cycles later, correct.
//  5 rst_n=0 for one cycle at ACCUM beat 4 -> next cycle busy=0, in_ready=1, out_valid=0; following frame (test 1) gives 55.
//  6 LANES=3: test 1 gives 55 after 3 cycles; LANES=4: BEATS=3, tail lanes masked, still 55.

Source files
------------

// File: rtl/neuron_pkg.sv
// ============================================================================
// neuron_pkg: FSM state type and sizing helpers for neuron_mac_seq.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package neuron_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Accumulator width: enough headroom for bias plus N_IN weights.
  function automatic int acc_w(input int n_in, input int w);
    return w + $clog2(n_in + 1);
  endfunction

  function automatic int beats(input int n_in, input int lanes);
    return (n_in + lanes - 1) / lanes;
  endfunction

endpackage

`default_nettype wire

// File: rtl/neuron_sat.sv
// ============================================================================
// neuron_sat: narrows the ACC_W accumulator to W bits, clamping when
// NEURON_SAT_EN is defined, two's-complement wrap otherwise.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module neuron_sat #(
  parameter int ACC_W = 24,
  parameter int W     = 20
) (
  input  logic [ACC_W-1:0] i_acc,
  output logic [W-1:0]     o_c,
  output logic             o_sat
);

`ifdef NEURON_SAT_EN
  localparam logic [ACC_W-1:0] C_MAX = {{(ACC_W-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic [ACC_W-1:0] C_MIN = {{(ACC_W-W+1){1'b1}}, {(W-1){1'b0}}};

  always_comb begin
    o_c   = i_acc[W-1:0];
    o_sat = 1'b0;
    if ($signed(i_acc) > $signed(C_MAX)) begin
      o_c   = C_MAX[W-1:0];
      o_sat = 1'b1;
    end else if ($signed(i_acc) < $signed(C_MIN)) begin
      o_c   = C_MIN[W-1:0];
      o_sat = 1'b1;
    end
  end
`else
  logic unused_hi;

  assign o_c       = i_acc[W-1:0];
  assign o_sat     = 1'b0;
  assign unused_hi = ^i_acc[ACC_W-1:W];
`endif

endmodule

`default_nettype wire

// File: rtl/neuron_mac_seq.sv
// ============================================================================
// neuron_mac_seq: sequential weighted-sum neuron, C = B + sum(X[i] ? W[i] : 0),
// LANES pixels per cycle under valid/ready. Option macro: NEURON_SAT_EN.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module neuron_mac_seq
  import neuron_pkg::*;
#(
  parameter int N_IN  = 9,
  parameter int W     = 20,
  parameter int LANES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_IN-1:0]   in_x,
  input  logic [N_IN*W-1:0] in_w,
  input  logic [W-1:0]      in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      out_c,
  output logic              out_sat,
  output logic              busy
);

  localparam int ACC_W = acc_w(N_IN, W);
  localparam int BEATS = beats(N_IN, LANES);
  localparam int N_PAD = BEATS * LANES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  state_e            state_q, state_d;
  logic [N_IN-1:0]   x_q, x_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [BW-1:0]     idx_q, idx_d;
  logic [W-1:0]      c_q, c_d;
  logic              sat_q, sat_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;

  logic [N_PAD*W-1:0] w_pad;
  logic [N_PAD-1:0]   x_pad;
  logic [W-1:0]       lane_w [LANES];
  logic [LANES-1:0]   lane_x;
  logic [ACC_W-1:0]   sum;
  logic [W-1:0]       sat_c;
  logic               sat_flag;
  logic               last_beat;
  logic               accept;

  // Zero padding up to BEATS*LANES masks the tail lanes of the final beat.
  always_comb begin
    w_pad             = '0;
    w_pad[N_IN*W-1:0] = in_w;
    x_pad             = '0;
    x_pad[N_IN-1:0]   = x_q;
  end

  // Per-lane beat mux followed by the masked accumulate.
  always_comb begin
    sum    = acc_q;
    lane_x = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_w[l] = '0;
      for (int b = 0; b < BEATS; b++) begin
        if (idx_q == BW'(b)) begin
          lane_w[l] = w_pad[(b*LANES+l)*W +: W];
          lane_x[l] = x_pad[b*LANES+l];
        end
      end
      if (lane_x[l]) begin
        sum = sum + {{(ACC_W-W){lane_w[l][W-1]}}, lane_w[l]};
      end
    end
  end

  neuron_sat #(
    .ACC_W (ACC_W),
    .W     (W)
  ) u_sat (
    .i_acc (sum),
    .o_c   (sat_c),
    .o_sat (sat_flag)
  );

  assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign last_beat = (idx_q == BW'(BEATS - 1));

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    c_d     = c_q;
    sat_d   = sat_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          x_d     = in_x;
          acc_d   = {{(ACC_W-W){in_b[W-1]}}, in_b};
          idx_d   = '0;
          state_d = ST_ACCUM;
          busy_d  = 1'b1;
        end
      end
      ST_ACCUM: begin
        acc_d = sum;
        idx_d = idx_q + BW'(1);
        if (last_beat) begin
          c_d     = sat_c;
          sat_d   = sat_flag;
          valid_d = 1'b1;
          idx_d   = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          valid_d = 1'b0;
          // A waiting frame is taken on the same edge the result pops.
          if (in_valid) begin
            x_d     = in_x;
            acc_d   = {{(ACC_W-W){in_b[W-1]}}, in_b};
            idx_d   = '0;
            state_d = ST_ACCUM;
          end else begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      c_q     <= '0;
      sat_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      c_q     <= c_d;
      sat_q   <= sat_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign out_valid = valid_q;
  assign out_c     = c_q;
  assign out_sat   = sat_q;
  assign busy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_neuron_mac_seq.sv
// ============================================================================
// tb_neuron_mac_seq: randomized self-checking bench against an arithmetic
// reference model (honours NEURON_SAT_EN). Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_neuron_mac_seq;

  localparam int N_IN = 9;
  localparam int W    = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n, in_valid, in_ready, out_valid, out_ready, out_sat, busy;
  logic [N_IN-1:0]   in_x;
  logic [N_IN*W-1:0] in_w;
  logic [W-1:0]      in_b, out_c;
  logic              aux_valid, aux_ready;
  logic              a3_ready, a3_valid, a3_sat, a3_busy;
  logic              a4_ready, a4_valid, a4_sat, a4_busy;
  logic [W-1:0]      a3_c, a4_c;

  neuron_mac_seq #(.N_IN(N_IN), .W(W), .LANES(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_w(in_w), .in_b(in_b), .out_valid(out_valid),
    .out_ready(out_ready), .out_c(out_c), .out_sat(out_sat), .busy(busy));

  neuron_mac_seq #(.N_IN(N_IN), .W(W), .LANES(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(aux_valid), .in_ready(a3_ready),
    .in_x(in_x), .in_w(in_w), .in_b(in_b), .out_valid(a3_valid),
    .out_ready(aux_ready), .out_c(a3_c), .out_sat(a3_sat), .busy(a3_busy));

  neuron_mac_seq #(.N_IN(N_IN), .W(W), .LANES(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(aux_valid), .in_ready(a4_ready),
    .in_x(in_x), .in_w(in_w), .in_b(in_b), .out_valid(a4_valid),
    .out_ready(aux_ready), .out_c(a4_c), .out_sat(a4_sat), .busy(a4_busy));

  int n_tests = 0;
  int n_fail  = 0;
  logic signed [W-1:0] wts [N_IN];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task tick;
    @(posedge clk);
    #1;
  endtask

  task load_w;
    for (int i = 0; i < N_IN; i++) in_w[i*W +: W] = wts[i];
  endtask

  // Reference: {sat, c} from plain signed arithmetic on the frame.
  function automatic logic [W:0] model(input logic [N_IN-1:0] x, input logic [W-1:0] b);
    longint s;
    s = longint'($signed(b));
    for (int i = 0; i < N_IN; i++) if (x[i]) s += longint'(wts[i]);
`ifdef NEURON_SAT_EN
    if (s > 524287)  return {1'b1, 20'h7FFFF};
    if (s < -524288) return {1'b1, 20'h80000};
`endif
    return {1'b0, s[W-1:0]};
  endfunction

  // One frame on the LANES=1 instance; hold = cycles of backpressure in DONE.
  task automatic run_frame(input string tag, input logic [N_IN-1:0] x,
                           input logic [W-1:0] b, input int hold);
    logic [W:0] exp;
    int cyc;
    load_w();
    exp       = model(x, b);
    out_ready = (hold == 0);
    cyc = 0;
    while (!in_ready && cyc < 50) begin tick(); cyc++; end
    check({tag, "_in_ready"}, in_ready, 1);
    in_x = x; in_b = b; in_valid = 1'b1;
    tick();
    cyc = 0;
    while (!out_valid && cyc < 50) begin
      in_valid = 1'(($urandom & 32'h1) != 0);
      in_x = N_IN'($urandom); in_b = W'($urandom);
      tick(); cyc++;
    end
    in_valid = 1'b0;
    check({tag, "_lat"}, cyc, 9);
    check({tag, "_c"}, out_c, exp[W-1:0]);
    check({tag, "_sat"}, out_sat, exp[W]);
    for (int k = 0; k < hold; k++) begin
      in_valid = 1'b1;
      tick();
      check({tag, "_hold_c"}, out_c, exp[W-1:0]);
      check({tag, "_hold_rdy"}, {out_valid, in_ready}, 2'b10);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check({tag, "_pop"}, {out_valid, busy}, 2'b00);
  endtask

  // One frame on the LANES=3 and LANES=4 instances together.
  task automatic run_aux(input string tag, input logic [N_IN-1:0] x, input logic [W-1:0] b);
    logic [W:0] exp;
    int lat3, lat4;
    logic [W:0] r3, r4;
    load_w();
    exp = model(x, b);
    lat3 = -1; lat4 = -1; r3 = '0; r4 = '0;
    in_x = x; in_b = b; aux_valid = 1'b1;
    tick();
    aux_valid = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (a3_valid && lat3 < 0) begin lat3 = c - 1; r3 = {a3_sat, a3_c}; end
      if (a4_valid && lat4 < 0) begin lat4 = c - 1; r4 = {a4_sat, a4_c}; end
      tick();
    end
    check({tag, "_l3_lat"}, lat3, 3);
    check({tag, "_l3_res"}, r3, exp);
    check({tag, "_l4_lat"}, lat4, 3);
    check({tag, "_l4_res"}, r4, exp);
  endtask

  initial begin
    logic [W:0] exp;
    int cyc, seen;
    rst_n = 1'b0; in_valid = 1'b0; aux_valid = 1'b0; out_ready = 1'b1; aux_ready = 1'b1;
    in_x = '0; in_b = '0; in_w = '0;
    for (int i = 0; i < N_IN; i++) wts[i] = W'(i + 1);
    tick(); tick();
    check("rst_outs", {busy, out_valid, out_sat, out_c}, '0);
    check("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    tick();

    run_frame("t1_all_ones", 9'h1FF, 20'd10, 0);
    run_frame("t2_bias_only", 9'h000, 20'hFFFFB, 0);
    for (int i = 0; i < N_IN; i++) wts[i] = -20'sd100;
    run_frame("t2_neg", 9'b000010001, 20'd0, 1);
    for (int i = 0; i < N_IN; i++) wts[i] = 20'h7FFFF;
    run_frame("t3_overflow", 9'h1FF, 20'd0, 0);
    for (int i = 0; i < N_IN; i++) wts[i] = -20'sh80000;
    run_frame("t3_underflow", 9'h1FF, 20'hFFFFF, 0);

    // Backpressure then same-edge handoff to a second frame.
    for (int i = 0; i < N_IN; i++) wts[i] = W'(i + 1);
    load_w();
    out_ready = 1'b0;
    in_x = 9'h1FF; in_b = 20'd10; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 50) begin tick(); cyc++; end
    check("t4_lat_a", cyc, 9);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t4_hold", {out_valid, in_ready, out_c}, {2'b10, 20'd55});
    end
    exp = model(9'h0F0, 20'hFFFF0);
    out_ready = 1'b1; in_x = 9'h0F0; in_b = 20'hFFFF0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("t4_handoff", {out_valid, busy}, 2'b01);
    cyc = 0;
    while (!out_valid && cyc < 50) begin tick(); cyc++; end
    check("t4_lat_b", cyc, 9);
    check("t4_res_b", {out_sat, out_c}, exp);
    tick();

    // Reset in the middle of accumulation discards the frame.
    in_x = 9'h1FF; in_b = 20'd10; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("t5_after_rst", {busy, in_ready, out_valid}, 3'b010);
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      if (out_valid) seen++;
      tick();
    end
    check("t5_no_pulse", seen, 0);
    run_frame("t5_next", 9'h1FF, 20'd10, 0);

    run_aux("t6_lanes", 9'h1FF, 20'd10);

    for (int n = 0; n < 12; n++) begin
      for (int i = 0; i < N_IN; i++) wts[i] = W'($urandom);
      run_frame("rnd", N_IN'($urandom), W'($urandom), int'($urandom_range(0, 3)));
    end
    for (int n = 0; n < 4; n++) begin
      for (int i = 0; i < N_IN; i++) wts[i] = W'($urandom);
      run_aux("rnd_aux", N_IN'($urandom), W'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
